pmu_secure_loader: RTL and testbench

Programming management unit (PMU) for the secured-bitstream FPGA flow: it receives a serial configuration stream containing framed commands, loads a 128-bit AES key, decrypts encrypted payload blocks and shifts the plaintext out serially toward the configuration chain. It raises a power-up enable once a complete bitstream has been delivered. It sits between the external programming pin and the fabric configuration shift chain.

---
 rtl/pmu_pkg.sv | 29 ++
 rtl/pmu_cipher.sv | 71 +++++++
 rtl/pmu_secure_loader.sv | 192 +++++++++++++++++++
 tb/tb_pmu_secure_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU secure loader: FSM state encoding, command
// opcodes, header field positions and the cipher block type.
package pmu_pkg;

  localparam int unsigned BLOCK_W = 128;
  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [2:0] {
    StIdle,
    StSof,
    StHeader,
    StKey,
    StData,
    StDone,
    StError
  } state_e;

  localparam logic [3:0] OP_KEY_LOAD  = 4'h3;
  localparam logic [3:0] OP_BITSTREAM = 4'h5;

  // Header layout, bit 0 received first.
  localparam int unsigned HDR_OP_LSB  = 0;
  localparam int unsigned HDR_OP_MSB  = 3;
  localparam int unsigned HDR_LEN_LSB = 4;
  localparam int unsigned HDR_LEN_MSB = 19;
  // Length bits below this position are a partial block and are dropped.
  localparam int unsigned BLK_LOG2    = 7;

endpackage

// File: rtl/pmu_cipher.sv
// Block cipher stage for the PMU loader. Captures block and key on start_i
// and presents the result with valid_o exactly AES_LATENCY cycles later.
// Build option PMU_AES_EN: when defined, wraps the AES-128 decrypt core
// (whose own latency must not exceed AES_LATENCY); when undefined, a bypass
// model returns block XOR key.
// Ports: clk, rst (async, active-high), clr_i (abort in-flight operation),
//        start_i, block_i, key_i -> result_o, valid_o (one-cycle pulse).
module pmu_cipher
  import pmu_pkg::*;
#(
  parameter int unsigned AES_LATENCY = 10
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr_i,
  input  logic   start_i,
  input  block_t block_i,
  input  block_t key_i,
  output block_t result_o,
  output logic   valid_o
);

  logic [6:0] cnt_q, cnt_d;
  block_t     res_q, res_d;

`ifdef PMU_AES_EN
  block_t core_res;
  logic   core_vld;

  aes128_dec_core u_core (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start_i),
    .key_i    (key_i),
    .block_i  (block_i),
    .result_o (core_res),
    .valid_o  (core_vld)
  );
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d = 7'(AES_LATENCY);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 7'd1;
    end
`ifdef PMU_AES_EN
    // Hold the core result until the fixed-latency release point.
    res_d = core_vld ? core_res : res_q;
`else
    res_d = start_i ? (block_i ^ key_i) : res_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end

  assign valid_o  = (cnt_q == 7'd1);
  assign result_o = res_q;

endmodule

// File: rtl/pmu_secure_loader.sv
// Programming management unit: parses a serial LSB-first framed stream,
// loads a 128-bit key, passes ciphertext blocks through pmu_cipher and
// shifts plaintext out on tdo. pwr_up_en rises after the final bit leaves.
// Build option PMU_AES_EN selects the real AES core inside pmu_cipher.
// Ports: clk, rst (async, active-high), data_i (serial in), en (session
//        enable) -> pwr_up_en, tdo (serial plaintext, 0 when idle).
module pmu_secure_loader
  import pmu_pkg::*;
#(
  parameter int unsigned HEADER_WIDTH   = 32,
  parameter int unsigned AES_DATA_WIDTH = 128,
  parameter int unsigned AES_LATENCY    = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic data_i,
  input  logic en,
  output logic pwr_up_en,
  output logic tdo
);

  state_e                  state_q, state_d;
  // Holds header bits 0..30; bit 31 is reserved and never stored.
  logic [HEADER_WIDTH-2:0] hdr_q, hdr_d;
  logic [6:0]              bit_cnt_q, bit_cnt_d;
  block_t                  in_q, in_d, key_q, key_d, out_q, out_d;
  logic                    key_valid_q, key_valid_d;
  logic [8:0]              nblk_q, nblk_d, blk_in_q, blk_in_d, blk_out_q, blk_out_d;
  logic [7:0]              rem_q, rem_d;
  logic                    start_q, start_d, pwr_q, pwr_d;

  block_t     cipher_res;
  logic       cipher_vld;
  logic [3:0] hdr_op;
  logic [8:0] hdr_nblk;

  assign hdr_op   = hdr_q[HDR_OP_MSB:HDR_OP_LSB];
  assign hdr_nblk = hdr_q[HDR_LEN_MSB:HDR_LEN_LSB+BLK_LOG2];

  pmu_cipher #(
    .AES_LATENCY (AES_LATENCY)
  ) u_cipher (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!en),
    .start_i  (start_q),
    .block_i  (in_q),
    .key_i    (key_q),
    .result_o (cipher_res),
    .valid_o  (cipher_vld)
  );

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    bit_cnt_d   = bit_cnt_q;
    in_d        = in_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    nblk_d      = nblk_q;
    blk_in_d    = blk_in_q;
    blk_out_d   = blk_out_q;
    out_d       = out_q;
    rem_d       = rem_q;
    start_d     = 1'b0;
    pwr_d       = pwr_q;

    unique case (state_q)
      StIdle: state_d = StSof;
      StSof: begin
        // The first 1 bit is header bit 0 (opcode LSB); pad zeros are skipped.
        if (data_i) begin
          hdr_d     = {1'b1, {(HEADER_WIDTH-2){1'b0}}};
          bit_cnt_d = 7'd1;
          state_d   = StHeader;
        end
      end
      StHeader: begin
        if (bit_cnt_q == 7'(HEADER_WIDTH - 1)) begin
          bit_cnt_d = '0;
          state_d   = StSof;
          if (hdr_nblk != '0) begin
            if (hdr_op == OP_KEY_LOAD) begin
              state_d = StKey;
            end else if (hdr_op == OP_BITSTREAM) begin
              nblk_d    = hdr_nblk;
              blk_in_d  = '0;
              blk_out_d = '0;
              state_d   = key_valid_q ? StData : StError;
            end
          end
        end else begin
          hdr_d     = {data_i, hdr_q[HEADER_WIDTH-2:1]};
          bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end
      StKey: begin
        in_d = {data_i, in_q[BLOCK_W-1:1]};
        if (bit_cnt_q == 7'(AES_DATA_WIDTH - 1)) begin
          key_d       = in_d;
          key_valid_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = StSof;
        end else begin
          bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end
      StData: begin
        // Input side: stop sampling once every announced block is in.
        if (blk_in_q != nblk_q) begin
          in_d = {data_i, in_q[BLOCK_W-1:1]};
          if (bit_cnt_q == 7'(AES_DATA_WIDTH - 1)) begin
            start_d   = 1'b1;
            blk_in_d  = blk_in_q + 9'd1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
        // Output side: a new result can land on the same edge the previous
        // block's last bit retires, so retire and load are independent.
        if (rem_q == 8'd1) begin
          blk_out_d = blk_out_q + 9'd1;
          if (blk_out_q == nblk_q - 9'd1) begin
            state_d = StDone;
            pwr_d   = 1'b1;
          end
        end
        if (cipher_vld) begin
          out_d = cipher_res;
          rem_d = 8'(AES_DATA_WIDTH);
        end else if (rem_q != '0) begin
          out_d = {1'b0, out_q[BLOCK_W-1:1]};
          rem_d = rem_q - 8'd1;
        end
      end
      StDone, StError: begin
        state_d = state_q;
      end
      default: state_d = StIdle;
    endcase

    // Session abort: key material survives, everything else is cleared.
    if (!en) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      nblk_d    = '0;
      blk_in_d  = '0;
      blk_out_d = '0;
      out_d     = '0;
      rem_d     = '0;
      start_d   = 1'b0;
      pwr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hdr_q       <= '0;
      bit_cnt_q   <= '0;
      in_q        <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      nblk_q      <= '0;
      blk_in_q    <= '0;
      blk_out_q   <= '0;
      out_q       <= '0;
      rem_q       <= '0;
      start_q     <= 1'b0;
      pwr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      bit_cnt_q   <= bit_cnt_d;
      in_q        <= in_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      nblk_q      <= nblk_d;
      blk_in_q    <= blk_in_d;
      blk_out_q   <= blk_out_d;
      out_q       <= out_d;
      rem_q       <= rem_d;
      start_q     <= start_d;
      pwr_q       <= pwr_d;
    end
  end

  assign pwr_up_en = pwr_q;
  assign tdo       = (rem_q != '0) & out_q[0];

endmodule

// File: tb/tb_pmu_secure_loader.sv
// Directed bench for pmu_secure_loader (bypass cipher build). Expected tdo
// bits are pushed to a timed scoreboard when each block is driven and are
// popped and compared on the cycle they are due; tdo must be 0 otherwise.
module tb_pmu_secure_loader;
  import pmu_pkg::*;

  localparam int unsigned LAT = 10;

  logic clk = 1'b0;
  logic rst, data_i, en;
  logic pwr_up_en, tdo;

  always #5 clk = ~clk;

  pmu_secure_loader #(
    .HEADER_WIDTH   (32),
    .AES_DATA_WIDTH (128),
    .AES_LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .en        (en),
    .pwr_up_en (pwr_up_en),
    .tdo       (tdo)
  );

  typedef struct {
    int   cyc;
    logic b;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc     = 0;
  int           pwr_cyc = 0;
  int           errors  = 0;
  int           checks  = 0;
  logic [127:0] key_m   = '0;
  logic [127:0] key_v   = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] blk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive a bit, then check tdo and pwr_up_en against the model.
  task automatic step(input logic b);
    exp_t e;
    data_i = b;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("tdo_bit", tdo, e.b);
    end else begin
      chk("tdo_idle", tdo, 0);
    end
    chk("pwr_up_en", pwr_up_en, (pwr_cyc != 0 && cyc >= pwr_cyc));
  endtask

  task automatic send_word(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) step(v[i]);
  endtask

  task automatic send_block(input logic [127:0] b, input bit last);
    exp_t e;
    send_word(b, 128);
    for (int k = 0; k < 128; k++) begin
      e.cyc = cyc + 1 + LAT + k;
      e.b   = b[k] ^ key_m[k];
      exp_q.push_back(e);
    end
    if (last) pwr_cyc = cyc + LAT + 129;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() > 0 || cyc < pwr_cyc); i++) step(0);
    chk("drain_done", exp_q.size() == 0, 1);
  endtask

  task automatic drop_en();
    exp_q.delete();
    pwr_cyc = 0;
    en = 0;
    step(0);
  endtask

  initial begin
    rst = 1; en = 0; data_i = 0;
    #12;
    chk("rst_tdo", tdo, 0);
    chk("rst_pwr", pwr_up_en, 0);
    chk("rst_key_valid", dut.key_valid_q, 0);
    chk("rst_key", dut.key_q, 0);
    chk("rst_state", dut.state_q, StIdle);
    rst = 0;
    step(0); step(0);

    // Bitstream without a key goes to ERROR and stays silent.
    en = 1; step(0); step(0);
    send_word(32'h00004005, 32);
    chk("err_state", dut.state_q, StError);
    repeat (40) step(1);
    chk("err_hold", dut.state_q, StError);
    drop_en();
    chk("err_to_idle", dut.state_q, StIdle);

    // Unknown opcode discarded, then a key frame with trailing pad zeros.
    en = 1; step(0); step(0);
    send_word(32'h00008007, 32);
    chk("bad_op_sof", dut.state_q, StSof);
    send_word(32'h00000803, 32);
    send_word(key_v, 127);
    chk("key_valid_pre", dut.key_valid_q, 0);
    step(key_v[127]);
    chk("key_valid_post", dut.key_valid_q, 1);
    chk("key_value", dut.key_q, key_v);
    key_m = key_v;
    send_word('0, 4);

    // Eight all-zero blocks: each comes out as the key.
    send_word(32'h00004005, 32);
    chk("data_state", dut.state_q, StData);
    for (int b = 0; b < 8; b++) send_block('0, (b == 7));
    drain();
    step(0);
    chk("pwr_done", pwr_up_en, 1);
    chk("done_state", dut.state_q, StDone);
    drop_en();
    chk("key_kept_done", dut.key_q, key_v);

    // Abort in the middle of block 3.
    en = 1; step(0);
    send_word(32'h00004005, 32);
    for (int b = 0; b < 3; b++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      send_block(blk, 0);
    end
    blk = {$urandom, $urandom, $urandom, $urandom};
    send_word(blk, 60);
    drop_en();
    chk("abort_state", dut.state_q, StIdle);
    chk("abort_key_kept", dut.key_q, key_v);
    chk("abort_key_valid", dut.key_valid_q, 1);
    step(0); step(0);

    // Rerun of the bitstream frame alone, random ciphertext.
    en = 1; step(0);
    send_word(32'h00004005, 32);
    for (int b = 0; b < 8; b++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      send_block(blk, (b == 7));
    end
    drain();
    step(0);
    chk("pwr_rerun", pwr_up_en, 1);
    drop_en();

    // Reset in DATA while tdo is driving ones (block = ~key).
    en = 1; step(0);
    send_word(32'h00004005, 32);
    send_block(~key_v, 0);
    send_word('0, 40);
    chk("tdo_pre_rst", tdo, 1);
    #3;
    rst = 1;
    #1;
    chk("rst_mid_tdo", tdo, 0);
    chk("rst_mid_pwr", pwr_up_en, 0);
    chk("rst_mid_key_valid", dut.key_valid_q, 0);
    chk("rst_mid_key", dut.key_q, 0);
    exp_q.delete();
    pwr_cyc = 0;
    key_m = '0;
    en = 0;
    #1;
    rst = 0;
    step(0); step(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
